// File: rtl/credit_pkg.sv
// credit_pkg: shared credit-link sizing so sender and receiver agree on the credit count
package credit_pkg;
    localparam int CREDIT_DEPTH = 8;
    localparam int CREDIT_WIDTH = 8;
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: DEPTH x WIDTH register array, synchronous write, asynchronous read
module fifo_ram #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    // storage is deliberately unreset; only occupancy decides validity
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/credit_rx_fifo.sv
// credit_rx_fifo: receiver show-ahead FIFO returning one credit per drained entry
module credit_rx_fifo
    import credit_pkg::*;
#(
    parameter int DEPTH     = CREDIT_DEPTH,
    parameter int WIDTH     = CREDIT_WIDTH,
    parameter int CNT_WIDTH = cnt_width(DEPTH),
    parameter int PTR_WIDTH = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_data,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    input  logic                 out_ready,
    output logic                 credit_ret,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 overflow,
    output logic                 underflow
);
    logic [PTR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [CNT_WIDTH-1:0] outstanding, outstanding_nxt;
    logic                 pop, full, push_acc;

    assign out_valid = count != '0;
    assign full      = count == CNT_WIDTH'(DEPTH);
    assign pop       = out_valid && out_ready;
    assign push_acc  = push && (!full || pop);

    // sender credit shadow; holds at zero on an illegal push so it cannot wrap
    always_comb begin
        outstanding_nxt = outstanding;
        if (push_acc && !credit_ret)
            outstanding_nxt = (outstanding == '0) ? outstanding : outstanding - 1'b1;
        else if (!push_acc && credit_ret)
            outstanding_nxt = outstanding + 1'b1;
    end

    // pointers wrap by compare-and-clear so any DEPTH works
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            credit_ret  <= 1'b0;
            outstanding <= CNT_WIDTH'(DEPTH);
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            if (push_acc) wr_ptr <= (wr_ptr == PTR_WIDTH'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop) rd_ptr <= (rd_ptr == PTR_WIDTH'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            count       <= count + CNT_WIDTH'(push_acc) - CNT_WIDTH'(pop);
            credit_ret  <= pop;
            outstanding <= outstanding_nxt;
            overflow    <= overflow | (push && full && !pop);
            underflow   <= underflow | (push && outstanding == '0);
        end
    end

    fifo_ram #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(PTR_WIDTH)) u_ram (
        .clk   (clk),
        .we    (push_acc),
        .waddr (wr_ptr),
        .wdata (push_data),
        .raddr (rd_ptr),
        .rdata (out_data)
    );

`ifdef FORMAL
    a_count_max: assert property (@(posedge clk) disable iff (rst) count <= CNT_WIDTH'(DEPTH));
    a_credit_inv: assert property (@(posedge clk) disable iff (rst)
        !underflow |-> (int'(outstanding) + int'(count) + int'(credit_ret) == DEPTH));
    a_ret_after_pop: assert property (@(posedge clk) disable iff (rst) credit_ret |-> $past(pop));
`endif
endmodule

// File: tb/tb_credit_rx_fifo.sv
// tb_credit_rx_fifo: table-driven and directed checks of the credit receiver FIFO
module tb_credit_rx_fifo;
    logic       clk = 1'b0;
    logic       rst, push, out_ready, out_valid, credit_ret, overflow, underflow;
    logic [7:0] push_data, out_data;
    logic [3:0] count;
    int         tests = 0;
    int         fails = 0;

    typedef struct {
        logic       push;
        logic [7:0] pd;
        logic       rdy;
        logic       ev;
        logic [7:0] ed;
        logic       ecr;
        logic [3:0] ecnt;
        logic       eovf;
        logic       eunf;
    } vec_t;
    vec_t vq[$];

    credit_rx_fifo dut (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (push_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .credit_ret (credit_ret),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ev, input logic [7:0] ed, input logic ecr,
                             input logic [3:0] ecnt, input logic eovf, input logic eunf);
        chk({tag, " out_valid"}, int'(out_valid), int'(ev));
        if (ev) chk({tag, " out_data"}, int'(out_data), int'(ed));
        chk({tag, " credit_ret"}, int'(credit_ret), int'(ecr));
        chk({tag, " count"}, int'(count), int'(ecnt));
        chk({tag, " overflow"}, int'(overflow), int'(eovf));
        chk({tag, " underflow"}, int'(underflow), int'(eunf));
    endtask

    function automatic vec_t mk(input logic p, input logic [7:0] pd, input logic r, input logic ev,
                                input logic [7:0] ed, input logic ecr, input logic [3:0] c,
                                input logic o, input logic u);
        vec_t t;
        t.push = p; t.pd = pd; t.rdy = r; t.ev = ev; t.ed = ed;
        t.ecr = ecr; t.ecnt = c; t.eovf = o; t.eunf = u;
        return t;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; push = 1'b0; out_ready = 1'b0; push_data = 8'h00;
        @(negedge clk);
        rst = 1'b0;
    endtask

    int pulses;

    initial begin
        // each record: inputs driven this cycle, outputs expected before the next edge
        for (int i = 0; i < 5; i++) vq.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 4'd0, 0, 0));
        for (int k = 0; k < 8; k++)
            vq.push_back(mk(1, 8'(k + 1), 0, k > 0, 8'h01, 0, 4'(k), 0, 0));
        vq.push_back(mk(1, 8'hAA, 0, 1, 8'h01, 0, 4'd8, 0, 0));
        vq.push_back(mk(0, 8'h00, 0, 1, 8'h01, 0, 4'd8, 1, 1));
        for (int j = 0; j < 8; j++)
            vq.push_back(mk(0, 8'h00, 1, 1, 8'(j + 1), j > 0, 4'(8 - j), 1, 1));
        vq.push_back(mk(0, 8'h00, 0, 0, 8'h00, 1, 4'd0, 1, 1));
        vq.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 4'd0, 1, 1));

        rst = 1'b1; push = 1'b0; out_ready = 1'b0; push_data = 8'h00;
        #1;
        check_all("reset", 0, 8'h00, 0, 4'd0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (vq[n]) begin
            @(negedge clk);
            push = vq[n].push; push_data = vq[n].pd; out_ready = vq[n].rdy;
            check_all($sformatf("vec%0d", n), vq[n].ev, vq[n].ed, vq[n].ecr, vq[n].ecnt, vq[n].eovf, vq[n].eunf);
        end

        // streaming: one entry resident, push and pop every cycle across two pointer wraps
        do_reset();
        push = 1'b1; push_data = 8'h10; out_ready = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            push = 1'b1; push_data = 8'(8'h11 + i); out_ready = 1'b1;
            check_all($sformatf("stream%0d", i), 1, 8'(8'h10 + i), i > 0, 4'd1, 0, 0);
            if (credit_ret) pulses++;
        end
        @(negedge clk);
        push = 1'b0; out_ready = 1'b0;
        check_all("stream_end", 1, 8'h24, 1, 4'd1, 0, 0);
        if (credit_ret) pulses++;
        chk("stream_pulses", pulses, 20);
        @(negedge clk);
        chk("stream_idle_cr", int'(credit_ret), 0);

        // mid-stream reset with occupancy 5 and a credit in flight
        do_reset();
        for (int i = 0; i < 6; i++) begin
            push = 1'b1; push_data = 8'(8'h30 + i);
            @(negedge clk);
        end
        push = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_all("pre_rst", 1, 8'h31, 1, 4'd5, 0, 0);
        rst = 1'b1;
        #1;
        check_all("mid_rst", 0, 8'h00, 0, 4'd0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push = 1'b1; push_data = 8'(8'h50 + i);
            @(negedge clk);
            chk($sformatf("refill%0d overflow", i), int'(overflow), 0);
        end
        push = 1'b0;
        check_all("refill_full", 1, 8'h50, 0, 4'd8, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/credit_rx_fifo.md
# credit_rx_fifo

Receiver-side endpoint of the credit-based link: an 8-entry show-ahead FIFO that accepts sender pushes and returns one credit per entry drained. It pairs with the sender's credit counter. The sender starts with DEPTH credits, decrements on each push and increments on each `credit_ret` pulse. Overflow and underflow are detected and flagged here rather than prevented.

## Interface
- `DEPTH`, 8: buffer entries; equals the sender's initial credit count.
- `WIDTH`, 8: payload width in bits.
- `CNT_WIDTH`, $clog2(DEPTH+1): occupancy counter width.
- `PTR_WIDTH`, $clog2(DEPTH): read/write pointer width (DEPTH ≥ 2).

Ports:
- `clk`  in  1  sole clock; all state on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `push`  in  1  sender transfer strobe; legal only while the sender holds a credit.
- `push_data`  in  WIDTH  payload qualified by `push`.
- `out_valid`  out  1  FIFO non-empty.
- `out_data`  out  WIDTH  head entry; valid when `out_valid`.
- `out_ready`  in  1  consumer accepts head.
- `credit_ret`  out  1  registered one-cycle credit-return pulse to the sender.
- `count`  out  CNT_WIDTH  current occupancy.
- `overflow`  out  1  sticky: push arrived with no free slot.
- `underflow`  out  1  sticky: credit accounting error (see Operation).

## Operation
- Pop fires when `out_valid && out_ready`; `pop` denotes this condition.
- Push is accepted when `push && (count < DEPTH || pop)`. Write `push_data` at `wr_ptr`, then advance `wr_ptr`.
- Push when `count == DEPTH && !pop`: data is dropped, pointers and count are unchanged, and `overflow` sets.
- Pop: advance `rd_ptr`. Set `credit_ret` on the next cycle.
- `count` next value = `count + push_acc - pop`. Simultaneous push and pop leaves `count` unchanged. Push and pop are legal together at full and at empty; at empty, pop cannot fire because `out_valid` is 0.
- Pointers wrap from DEPTH-1 to 0. For non-power-of-2 DEPTH, use explicit compare-and-clear, not natural overflow.
- Credit shadow: an internal `outstanding` counter (CNT_WIDTH) tracks credits held by the sender.
  - Resets to DEPTH.
  - Decrements per accepted push and increments per `credit_ret`.
  - Invariant: `outstanding + count + credit_ret_pending == DEPTH`.
  - A push seen while `outstanding == 0` sets `underflow`. The push itself is still processed by the occupancy rule.
- `overflow` and `underflow` clear only on `rst`.
- The block issues no credits after reset. The sender's reset value must be exactly DEPTH.

## Timing
- Reset values: `out_valid` = 0, `out_data` = mem[0] (don't-care), `credit_ret` = 0, `count` = 0, `overflow` = 0, `underflow` = 0; pointers = 0; `outstanding` = DEPTH. Memory contents are not reset.
- Push to `out_valid` latency: 1 cycle. An entry pushed at edge N is visible after edge N, and `out_valid` is high in cycle N+1.
- `out_data` and `out_valid` are combinational from registered state (`rd_ptr`, `count`); no combinational path from `push` or `out_ready` to them.
- Pop to `credit_ret` latency: 1 cycle. Pop at edge N produces `credit_ret` = 1 during cycle N+1 only. Back-to-back pops produce back-to-back pulses.
- Minimum credit loop: a sender seeing `credit_ret` can push in the following cycle. Sustained throughput is 1 entry/cycle with DEPTH ≥ 2.
- Asserting `rst` mid-operation immediately drops `out_valid`, `credit_ret` and the flags. In-flight credits are discarded, so the sender must be reset in the same cycle.

## Structure
- Shared package/include `credit_pkg` holds the default DEPTH, default WIDTH and the CNT_WIDTH derivation, so sender and receiver agree on the credit count.
- Sub-module `fifo_ram`: DEPTH×WIDTH register array with a synchronous write port and an asynchronous read port. Pointers, count, credit logic and flags stay in `credit_rx_fifo`.
- Formal properties, enabled under the codebase's formal define:
  - `count <= DEPTH`.
  - Credit-shadow invariant holds.
  - `credit_ret` is never high two cycles after reset without a prior pop.

## Test plan
All scenarios use DEPTH = 8 and WIDTH = 8.
- Reset then idle 5 cycles -> `count` = 0, `out_valid` = 0, `credit_ret` = 0, flags = 0.
- Push 0x01..0x08 on consecutive cycles, `out_ready` = 0 -> `count` = 8, `out_data` = 0x01, no `credit_ret`, `overflow` = 0.
- From full, hold `out_ready` = 1 for 8 cycles -> `out_data` sequence 0x01..0x08; `credit_ret` high for 8 consecutive cycles, each 1 cycle after its pop; `count` returns to 0.
- Push and pop every cycle for 20 cycles starting from `count` = 1 -> `count` stays 1, data in order, pointers wrap twice, 20 `credit_ret` pulses.
- At full, push 0xAA with `out_ready` = 0 -> `overflow` = 1, `count` = 8, 0xAA never appears at `out_data`. A 9th push with `outstanding` = 0 also sets `underflow` = 1.
- Assert `rst` mid-stream with `count` = 5 and a `credit_ret` pending -> all outputs zero in the same cycle; afterwards 8 pushes are accepted without `overflow`.
